// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with bounded tenure: IDLE arbitrates, GRANT holds one
// requester for at most MAX_HOLD cycles, and RELEASE advances the priority pointer.
module round_robin_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid,
  output logic           timeout
);

  localparam int HCW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int IDW1 = IDW + 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(MAX_HOLD - 1);
  localparam logic [IDW:0]    N_W       = IDW1'(N);
  localparam logic [IDW-1:0]  LAST_ID   = IDW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_ptr;
  logic [IDW-1:0] r_owner;
  logic [IDW-1:0] w_owner;
  logic [HCW-1:0] r_hold_cnt;
  logic [HCW-1:0] w_hold_cnt;
  logic [N-1:0]   r_grant;
  logic [N-1:0]   w_grant;
  logic [IDW-1:0] r_grant_id;
  logic [IDW-1:0] w_grant_id;
  logic           r_grant_valid;
  logic           w_grant_valid;
  logic           r_timeout;
  logic           w_timeout;
  logic [IDW-1:0] w_pick;

  // First requester at or after ptr, wrapping modulo N.
  function automatic logic [IDW-1:0] f_pick(input logic [N-1:0]   req_v,
                                             input logic [IDW-1:0] ptr_v);
    logic [IDW-1:0] sel;
    logic           found;
    logic [IDW:0]   sum;
    logic [IDW:0]   pos;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_v} + IDW1'(k);
      pos = (sum >= N_W) ? (sum - N_W) : sum;
      if (!found && req_v[pos[IDW-1:0]]) begin
        sel   = pos[IDW-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    w_state       = r_state;
    w_ptr         = r_ptr;
    w_owner       = r_owner;
    w_hold_cnt    = r_hold_cnt;
    w_grant       = '0;
    w_grant_id    = '0;
    w_grant_valid = 1'b0;
    w_timeout     = 1'b0;
    w_pick        = f_pick(req, r_ptr);
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state         = S_GRANT;
          w_owner         = w_pick;
          w_hold_cnt      = '0;
          w_grant[w_pick] = 1'b1;
          w_grant_id      = w_pick;
          w_grant_valid   = 1'b1;
        end else begin
          w_state = S_IDLE;
        end
      end
      // A dropped request takes precedence over the hold limit: no timeout then.
      S_GRANT: begin
        if (!req[r_owner]) begin
          w_state    = S_RELEASE;
          w_hold_cnt = '0;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state    = S_RELEASE;
          w_hold_cnt = '0;
          w_timeout  = 1'b1;
        end else begin
          w_hold_cnt    = r_hold_cnt + HCW'(1);
          w_grant       = r_grant;
          w_grant_id    = r_owner;
          w_grant_valid = 1'b1;
        end
      end
      S_RELEASE: begin
        w_ptr   = (r_owner == LAST_ID) ? '0 : (r_owner + IDW'(1));
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_owner       <= '0;
      r_hold_cnt    <= '0;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_ptr         <= w_ptr;
      r_owner       <= w_owner;
      r_hold_cnt    <= w_hold_cnt;
      r_grant       <= w_grant;
      r_grant_id    <= w_grant_id;
      r_grant_valid <= w_grant_valid;
      r_timeout     <= w_timeout;
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_valid = r_grant_valid;
  assign timeout     = r_timeout;

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 Parameter SHALL be N, default 4, number of requesters (legal 2..16).
REQ-002 Parameter SHALL be MAX_HOLD, default 8, maximum consecutive grant cycles per tenure (legal >= 1).
REQ-003 Port SHALL be clk  input  1  sole clock; all state on rising edge.
REQ-004 Port SHALL be reset  input  1  synchronous, active-high reset.
REQ-005 Port SHALL be req  input  N  request vector; bit i = requester i; level-held by requester until served.
REQ-006 Port SHALL be grant  output  N  registered one-hot grant; all-zero when nothing granted.
REQ-007 Port SHALL be grant_id  output  IDW=max(1,$clog2(N))  binary index of granted requester; 0 when grant_valid=0.
REQ-008 Port SHALL be grant_valid  output  1  high exactly when grant is non-zero.
REQ-009 Port SHALL be timeout  output  1  one-cycle pulse when a tenure is ended by MAX_HOLD expiry.

Function
REQ-010 FSM SHALL have three states: IDLE, GRANT, RELEASE; all outputs driven from registers, no combinational req-to-grant path.
REQ-011 Internal pointer ptr (IDW bits) SHALL hold the highest-priority index; search order ptr, ptr+1, ..., wrapping modulo N.
REQ-012 IDLE, req==0: SHALL stay in IDLE, outputs zero.
REQ-013 IDLE, req!=0: at that edge SHALL select first set bit in search order, enter GRANT, set grant/grant_id/grant_valid for that index, clear hold_cnt; grant visible the cycle after req sampled (latency 1).
REQ-014 GRANT: hold_cnt SHALL count cycles of current tenure, first grant cycle = 0.
REQ-015 GRANT, req[grant_id]==0 at edge: SHALL enter RELEASE, clear grant outputs, no timeout.
REQ-016 GRANT, req[grant_id]==1 and hold_cnt==MAX_HOLD-1: SHALL enter RELEASE, clear grant outputs, pulse timeout for the RELEASE cycle.
REQ-017 GRANT otherwise: SHALL hold grant and increment hold_cnt; grant never exceeds MAX_HOLD consecutive cycles.
REQ-018 Simultaneous req drop and hold limit: drop SHALL win; release without timeout.
REQ-019 RELEASE: SHALL set ptr = (grant_id+1) mod N, outputs zero, go to IDLE unconditionally; minimum gap between tenures is 2 cycles (RELEASE, IDLE).
REQ-020 Requests of other requesters during GRANT SHALL be ignored and not latched; only req in IDLE is arbitrated.
REQ-021 Fairness: a continuously asserted requester SHALL be granted within (N-1)*(MAX_HOLD+2)+2 cycles of assertion.
REQ-022 grant SHALL never have more than one bit set; grant_valid SHALL equal |grant in every cycle.
REQ-023 Counter hold_cnt SHALL be wide enough for MAX_HOLD-1 without wrap.

Reset
REQ-024 With reset=1 at a rising edge, state SHALL become IDLE, ptr=0, hold_cnt=0, grant=0, grant_id=0, grant_valid=0, timeout=0, regardless of state or req.
REQ-025 Reset asserted mid-tenure SHALL drop grant the following cycle with no timeout pulse; first post-reset arbitration uses ptr=0.
REQ-026 No output SHALL be X after the first reset edge.

Verification (N=4, MAX_HOLD=4)
REQ-027 Reset, then req=0001 -> next cycle grant=0001, grant_id=0, grant_valid=1; held while req[0]=1 up to 4 cycles.
REQ-028 req=1111 held constantly -> grants 0001,0010,0100,1000,0001 in order, each 4 cycles, timeout pulse after each, 2 zero cycles between tenures.
REQ-029 req=0001 granted, req[0] dropped after 2 grant cycles -> grant=0000 next cycle, timeout=0, then req=0011 -> requester 1 granted first (ptr=1).
REQ-030 req[2] dropped exactly on edge where hold_cnt=3 -> release, timeout stays 0.
REQ-031 reset pulsed during grant=0100 with req=1111 -> grant=0000 next cycle, then grant=0001 (not 1000).
REQ-032 req=0011 constant, req[3] asserted mid-stream -> req[3] granted within 20 cycles; one-hot and grant_valid invariants checked every cycle.
